// File: rtl/core_fetch_pkg.sv
// rtl/core_fetch_pkg.sv - shared types and constants for the instruction fetch stage
//
// Purpose: word/ptr types, the NOP presented when no instruction is available,
//          the fetch FSM state encoding and the prefetch queue entry layout.
package core_fetch_pkg;

  typedef logic [31:0] word;
  typedef logic [29:0] ptr;

  // addi x0, x0, 0
  localparam word NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_WAIT    = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state;

  typedef struct packed {
    word insn;
    ptr  pc;
  } fetch_entry;

endpackage

// File: rtl/core_fetch_prefetch.sv
// rtl/core_fetch_prefetch.sv - synchronous prefetch FIFO of {insn, pc}
//
// Purpose: small FIFO between the bus side and the decode side of fetch.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push         write push_data at the tail
//   push_data    entry to write
//   pop          advance the head (ignored when empty)
//   flush        empty the queue; overrides push and pop
//   head         entry at the head (meaningful only when !empty)
//   empty        queue holds no entries
//   count        number of valid entries, 0..DEPTH
module core_fetch_prefetch
  import core_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry               push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry               head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  fetch_entry    r_mem [DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;

  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

  assign count  = r_wr - r_rd;
  assign empty  = (r_wr == r_rd);
  assign w_full = (count == FULL_COUNT);

  // A push into a full queue is only accepted when the head leaves the same cycle.
  assign w_do_pop  = pop & ~empty & ~flush;
  assign w_do_push = push & ~flush & (~w_full | w_do_pop);

  assign head = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Payload storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/core_fetch.sv
// rtl/core_fetch.sv - instruction fetch stage feeding core_control
//
// Purpose: issues one word read at a time, queues returned words with their PCs,
//          presents the queue head to control, honours stall and branch redirect,
//          and drops the in-flight word that a redirect made stale.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   stall          hold the current head
//   branch         redirect pulse; branch_target is the next fetch ptr
//   fetch_ready    bus read complete, fetch_data valid
//   fetch_data     returned word
//   fetch_start    start read at fetch_addr (1-cycle pulse)
//   fetch_addr     read word address
//   insn_valid     queue head valid
//   insn, insn_pc  queue head word and its PC (insn = NOP_INSN when empty)
module core_fetch
  import core_fetch_pkg::*;
#(
  parameter int          PREFETCH_DEPTH = 4,
  parameter logic [29:0] RESET_PC       = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic [29:0] branch_target,
  input  logic        fetch_ready,
  input  logic [31:0] fetch_data,
  output logic        fetch_start,
  output logic [29:0] fetch_addr,
  output logic        insn_valid,
  output logic [31:0] insn,
  output logic [29:0] insn_pc
);

  localparam int CW = $clog2(PREFETCH_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(PREFETCH_DEPTH);

  fetch_state    r_state;
  fetch_state    w_next_state;
  ptr            r_fetch_pc;
  ptr            w_next_pc;

  logic          w_start;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_count;
  fetch_entry    w_head;
  fetch_entry    w_push_entry;

  assign w_full = (w_count == FULL_COUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH_IDLE;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_next_state;
      r_fetch_pc <= w_next_pc;
    end
  end

  // Redirect outranks everything: it retargets fetch_pc and, if a read is
  // outstanding, makes sure its data never reaches the queue.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_fetch_pc;
    w_start      = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      FETCH_IDLE: begin
        if (branch) begin
          w_next_pc = branch_target;
        end else if (!w_full) begin
          w_start      = 1'b1;
          w_next_state = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (branch) begin
          w_next_pc    = branch_target;
          w_next_state = fetch_ready ? FETCH_IDLE : FETCH_DISCARD;
        end else if (fetch_ready) begin
          w_push       = 1'b1;
          w_next_pc    = r_fetch_pc + 30'd1;
          w_next_state = FETCH_IDLE;
        end
      end
      FETCH_DISCARD: begin
        if (branch)      w_next_pc    = branch_target;
        if (fetch_ready) w_next_state = FETCH_IDLE;
      end
      default: w_next_state = FETCH_IDLE;
    endcase
  end

  // The reset state is IDLE, which would otherwise request a read while rst is held.
  assign fetch_start = w_start & ~rst;
  assign fetch_addr  = r_fetch_pc;

  assign w_pop = ~w_empty & ~stall & ~branch;

  assign w_push_entry.insn = fetch_data;
  assign w_push_entry.pc   = r_fetch_pc;

  core_fetch_prefetch #(
    .DEPTH (PREFETCH_DEPTH)
  ) u_prefetch (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (branch),
    .head      (w_head),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign insn_valid = ~w_empty;
  assign insn       = w_empty ? NOP_INSN : w_head.insn;
  assign insn_pc    = w_head.pc;

endmodule

// File: tb/tb_core_fetch.sv
// tb/tb_core_fetch.sv - scoreboard bench for core_fetch
module tb_core_fetch;
  import core_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [29:0] branch_target = '0;
  logic        fetch_ready = 1'b0;
  logic [31:0] fetch_data = '0;
  logic        fetch_start;
  logic [29:0] fetch_addr;
  logic        insn_valid;
  logic [31:0] insn;
  logic [29:0] insn_pc;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  int cyc     = 0;

  logic [61:0] exp_q[$];
  logic [29:0] starts[$];
  int          start_cyc[$];
  int          pop_cyc[$];

  int          lat = 1;
  logic        bus_pend = 1'b0;
  int          bus_cnt = 0;
  logic [29:0] bus_addr = '0;

  core_fetch #(.PREFETCH_DEPTH(4), .RESET_PC(30'd0)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch        (branch),
    .branch_target (branch_target),
    .fetch_ready   (fetch_ready),
    .fetch_data    (fetch_data),
    .fetch_start   (fetch_start),
    .fetch_addr    (fetch_addr),
    .insn_valid    (insn_valid),
    .insn          (insn),
    .insn_pc       (insn_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_data(input logic [29:0] a);
    return ({2'b00, a} + 32'd1) * 32'h11;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [29:0] pc);
    exp_q.push_back({exp_data(pc), pc});
  endtask

  // Bus model: one request at a time, ready pulses lat cycles after the start cycle.
  always @(negedge clk) begin
    fetch_ready = 1'b0;
    if (bus_pend) begin
      bus_cnt--;
      if (bus_cnt == 0) begin
        fetch_ready = 1'b1;
        fetch_data  = exp_data(bus_addr);
        bus_pend    = 1'b0;
      end
    end else if (fetch_start) begin
      bus_pend = 1'b1;
      bus_cnt  = lat;
      bus_addr = fetch_addr;
      starts.push_back(fetch_addr);
      start_cyc.push_back(cyc);
    end
  end

  // Monitor: every pop is compared against the scoreboard head.
  always @(negedge clk) begin
    logic [61:0] e;
    if (!insn_valid) begin
      n_tests++;
      if (insn !== NOP_INSN) begin
        n_fail++;
        $display("FAIL nop_when_empty: got %h expected %h", insn, NOP_INSN);
      end
    end
    if (!rst && insn_valid && !stall && !branch) begin
      n_pops++;
      pop_cyc.push_back(cyc);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pop: got insn=%h pc=%h expected no pop", insn, insn_pc);
      end else begin
        e = exp_q.pop_front();
        if ({insn, insn_pc} !== e) begin
          n_fail++;
          $display("FAIL pop: got insn=%h pc=%h expected insn=%h pc=%h",
                   insn, insn_pc, e[61:30], e[29:0]);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (6) @(posedge clk);
    #1;
    starts.delete();
    start_cyc.delete();
    pop_cyc.delete();
    rst = 1'b0;
  endtask

  task automatic wait_pops(input int target, input string name);
    int i = 0;
    while (n_pops < target && i < 200) begin
      @(posedge clk);
      i++;
    end
    #1;
    stall = 1'b1;
    check(name, n_pops >= target, 1);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_starts(input int n, input string name);
    int i = 0;
    while (starts.size() < n && i < 200) begin
      @(posedge clk);
      i++;
    end
    check(name, starts.size() >= n, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_insn_valid", insn_valid, 0);
    check("rst_insn", insn, NOP_INSN);
    check("rst_fetch_start", fetch_start, 0);
    check("rst_fetch_addr", fetch_addr, 30'd0);

    // Streaming with 1-cycle bus
    lat = 1; stall = 1'b0;
    do_reset();
    exp_push(30'd0); exp_push(30'd1); exp_push(30'd2);
    wait_pops(3, "stream_pops");
    check("stream_first_addr", starts[0], 30'd0);
    check("stream_period_a", pop_cyc[1] - pop_cyc[0], 2);
    check("stream_period_b", pop_cyc[2] - pop_cyc[1], 2);

    // Stall fills queue, then drains in order
    stall = 1'b1;
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    check("stall_push_count", starts.size(), 4);
    check("stall_no_start", fetch_start, 0);
    check("stall_head_valid", insn_valid, 1);
    check("stall_head_pc", insn_pc, 30'd0);
    check("stall_head_insn", insn, 32'h11);
    check("stall_fetch_addr", fetch_addr, 30'd4);
    for (int p = 0; p < 6; p++) exp_push(30'(p));
    base = n_pops;
    stall = 1'b0;
    wait_pops(base + 6, "stall_release_pops");

    // Branch during WAIT, bus answers 3 cycles after start
    lat = 3; stall = 1'b0; branch_target = 30'h100;
    do_reset();
    exp_push(30'h100); exp_push(30'h101);
    @(posedge clk); #1 branch = 1'b1;
    @(posedge clk); #1 branch = 1'b0;
    base = n_pops;
    wait_pops(base + 2, "brwait_pops");
    check("brwait_addr0", starts[0], 30'd0);
    check("brwait_addr1", starts[1], 30'h100);
    check("brwait_restart_gap", start_cyc[1] - start_cyc[0], 4);

    // Branch coincident with fetch_ready
    lat = 1; stall = 1'b0; branch_target = 30'h100;
    do_reset();
    exp_push(30'h100); exp_push(30'h101);
    @(posedge clk); #1 branch = 1'b1;
    @(posedge clk); #1 branch = 1'b0;
    base = n_pops;
    wait_pops(base + 2, "brready_pops");
    check("brready_addr1", starts[1], 30'h100);
    check("brready_restart_gap", start_cyc[1] - start_cyc[0], 2);

    // PC wrap at the top of the address space
    lat = 1; stall = 1'b0; branch_target = 30'h3FFF_FFFF;
    branch = 1'b1;
    do_reset();
    exp_push(30'h3FFF_FFFF); exp_push(30'h0); exp_push(30'h1);
    @(posedge clk); #1 branch = 1'b0;
    base = n_pops;
    wait_pops(base + 3, "wrap_pops");
    check("wrap_first_addr", starts[0], 30'h3FFF_FFFF);

    // Reset mid-WAIT with two queued entries
    lat = 1; stall = 1'b1;
    do_reset();
    wait_starts(2, "rstmid_two_starts");
    #1 lat = 4;
    wait_starts(3, "rstmid_third_start");
    @(posedge clk); #1;
    check("rstmid_pre_valid", insn_valid, 1);
    check("rstmid_pre_pc", insn_pc, 30'd0);
    #1 rst = 1'b1;
    #1;
    check("rstmid_async_valid", insn_valid, 0);
    check("rstmid_async_insn", insn, NOP_INSN);
    check("rstmid_async_start", fetch_start, 0);
    check("rstmid_async_addr", fetch_addr, 30'd0);
    exp_q.delete();
    lat = 1;
    stall = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    starts.delete();
    start_cyc.delete();
    pop_cyc.delete();
    rst = 1'b0;
    exp_push(30'd0); exp_push(30'd1);
    base = n_pops;
    wait_pops(base + 2, "rstmid_restart_pops");
    check("rstmid_restart_addr", starts[0], 30'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
